// File: rtl/md_pkg.sv
// Shared types and constants for the md_ctrl multiply/divide unit.
// Optional build macro MD_MUL_PIPE_EN (see md_ctrl) does not affect this package.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  // Widest supported word; narrower constants are sliced from these.
  localparam int          MD_MAX_WIDTH    = 64;
  localparam logic [63:0] MD_ALL_ONES_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MD_MOST_NEG_MAX = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring divider over unsigned magnitudes, one quotient bit per cycle.
// quotient_o/remainder_o carry the value being produced in the cycle done_o is high.
module md_div_iter import md_pkg::*; #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [WORD_SIZE-1:0] dividend_i,
  input  logic [WORD_SIZE-1:0] divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] quotient_o,
  output logic [WORD_SIZE-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WORD_SIZE + 1);

  logic [WORD_SIZE-1:0] quo_q, quo_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic [WORD_SIZE-1:0] div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE:0]   partial, trial;

  // The trial subtraction's top bit is set exactly when partial < divisor.
  always_comb begin
    partial = {rem_q, quo_q[WORD_SIZE-1]};
    trial   = partial - {1'b0, div_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      div_d = divisor_i;
      cnt_d = CNT_W'(WORD_SIZE);
    end else if (cnt_q != '0) begin
      if (!trial[WORD_SIZE]) begin
        rem_d = trial[WORD_SIZE-1:0];
        quo_d = {quo_q[WORD_SIZE-2:0], 1'b1};
      end else begin
        rem_d = partial[WORD_SIZE-1:0];
        quo_d = {quo_q[WORD_SIZE-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign done_o      = (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

endmodule

// File: rtl/md_ctrl.sv
// RV32M multiply/divide controller: single-cycle multiply, iterative divide, valid/ready handshakes.
// Define MD_MUL_PIPE_EN to register the product, giving a two-cycle MUL state.
module md_ctrl import md_pkg::*; #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           operator_i,
  input  logic [WORD_SIZE-1:0] operand_a_i,
  input  logic [WORD_SIZE-1:0] operand_b_i,
  input  logic [4:0]           rd_i,
  output logic [4:0]           rd_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WORD_SIZE-1:0] result_o,
  output logic                 busy_o
);

  localparam logic [WORD_SIZE-1:0] ALL_ONES = MD_ALL_ONES_MAX[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0] MOST_NEG = MD_MOST_NEG_MAX[MD_MAX_WIDTH-1 -: WORD_SIZE];

  md_state_e            state_q, state_d;
  md_op_e               op_q;
  logic [WORD_SIZE-1:0] opA_q, opB_q;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [4:0]           rd_q;
  logic                 negQuo_q, negRem_q;

  logic                 reqAccept, reqIsDiv, reqSigned, reqIsRem;
  logic                 divZero, divOverflow, divBypass, divStart;
  logic [WORD_SIZE-1:0] absA, absB, bypassResult;
  logic                 divBusy, divDone;
  logic [WORD_SIZE-1:0] divQuo, divRem, divResult;
  logic [2*WORD_SIZE-1:0] aExt, bExt, product;

  function automatic logic [WORD_SIZE-1:0] selectHalf(input md_op_e op,
                                                      input logic [2*WORD_SIZE-1:0] p);
    return (op == OP_MUL) ? p[WORD_SIZE-1:0] : p[2*WORD_SIZE-1:WORD_SIZE];
  endfunction

  // Request decode; divide special cases are resolved at accept time.
  always_comb begin
    reqAccept    = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    reqIsDiv     = operator_i[2];
    reqSigned    = !operator_i[0];
    reqIsRem     = operator_i[1];
    absA         = (reqSigned && operand_a_i[WORD_SIZE-1]) ? -operand_a_i : operand_a_i;
    absB         = (reqSigned && operand_b_i[WORD_SIZE-1]) ? -operand_b_i : operand_b_i;
    divZero      = (operand_b_i == '0);
    divOverflow  = reqSigned && (operand_a_i == MOST_NEG) && (operand_b_i == ALL_ONES);
    divBypass    = divZero || divOverflow;
    divStart     = reqAccept && reqIsDiv && !divBypass;
    bypassResult = '0;
    if (divZero) begin
      bypassResult = reqIsRem ? operand_a_i : ALL_ONES;
    end else if (divOverflow) begin
      bypassResult = reqIsRem ? '0 : operand_a_i;
    end
  end

  md_div_iter #(.WORD_SIZE(WORD_SIZE)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (divStart),
    .clear_i    (flush_i),
    .dividend_i (absA),
    .divisor_i  (absB),
    .busy_o     (divBusy),
    .done_o     (divDone),
    .quotient_o (divQuo),
    .remainder_o(divRem)
  );

  always_comb begin
    aExt    = {{WORD_SIZE{opA_q[WORD_SIZE-1] && (op_q == OP_MULH || op_q == OP_MULHSU)}}, opA_q};
    bExt    = {{WORD_SIZE{opB_q[WORD_SIZE-1] && (op_q == OP_MULH)}}, opB_q};
    product = aExt * bExt;
    if (op_q == OP_REM || op_q == OP_REMU) begin
      divResult = negRem_q ? -divRem : divRem;
    end else begin
      divResult = negQuo_q ? -divQuo : divQuo;
    end
  end

`ifdef MD_MUL_PIPE_EN
  logic [2*WORD_SIZE-1:0] prod_q;
  logic                   mulStage_q, mulStage_d;

  assign mulStage_d = (state_q == ST_MUL) && !mulStage_q && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      mulStage_q <= 1'b0;
    end else begin
      prod_q     <= product;
      mulStage_q <= mulStage_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (reqAccept) begin
          if (!reqIsDiv) begin
            state_d = ST_MUL;
          end else if (divBypass) begin
            state_d  = ST_DONE;
            result_d = bypassResult;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
`ifdef MD_MUL_PIPE_EN
        if (mulStage_q) begin
          state_d  = ST_DONE;
          result_d = selectHalf(op_q, prod_q);
        end
`else
        state_d  = ST_DONE;
        result_d = selectHalf(op_q, product);
`endif
      end
      ST_DIV: begin
        if (divDone) begin
          state_d  = ST_DONE;
          result_d = divResult;
        end else if (!divBusy) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over every handshake and discards anything being produced.
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      rd_q     <= '0;
      op_q     <= OP_MUL;
      opA_q    <= '0;
      opB_q    <= '0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (reqAccept) begin
        rd_q     <= rd_i;
        op_q     <= md_op_e'(operator_i);
        opA_q    <= operand_a_i;
        opB_q    <= operand_b_i;
        negQuo_q <= reqSigned && (operand_a_i[WORD_SIZE-1] ^ operand_b_i[WORD_SIZE-1]);
        negRem_q <= reqSigned && operand_a_i[WORD_SIZE-1];
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed vector table plus stall, flush and reset sequences.
// Latency is counted in rising edges from the accepting edge to the first edge after which rsp_valid_o is high.
module tb_md_ctrl;

  localparam int W = 32;
`ifdef MD_MUL_PIPE_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int NVEC    = 20;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic [W-1:0] expResult;
    int           expLat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [2:0]   operator_i;
  logic [W-1:0] operand_a_i;
  logic [W-1:0] operand_b_i;
  logic [4:0]   rd_i;
  logic [4:0]   rd_o;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] result_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;
  vec_t vecs [NVEC];

  md_ctrl #(.WORD_SIZE(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .rd_i        (rd_i),
    .rd_o        (rd_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Issue one request when ready, measure latency, check result/tag, then complete the handshake.
  task automatic applyStimulus(input vec_t v, input string name);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!req_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkFlag({name, " req_ready"}, req_ready_o, 1'b1);
    operator_i  = v.op;
    operand_a_i = v.a;
    operand_b_i = v.b;
    rd_i        = v.rd;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " result"}, result_o, v.expResult);
    checkOutput({name, " rd"}, {27'd0, rd_o}, {27'd0, v.rd});
    checkOutput({name, " latency"}, lat, v.expLat);
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    checkFlag({name, " idle after handshake"}, busy_o, 1'b0);
  endtask

  task automatic watchNoResponse(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) seen = 1'b1;
    end
    checkFlag(name, seen, 1'b0);
  endtask

  task automatic issueOnly(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] rd);
    @(negedge clk);
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    rd_i        = rd;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'b001, 32'd7,         32'hFFFF_FFFD, 5'd2,  32'hFFFF_FFFF, MUL_LAT};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MUL_LAT};
    vecs[3]  = '{3'b010, 32'd2,         32'hFFFF_FFFF, 5'd4,  32'h0000_0001, MUL_LAT};
    vecs[4]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         5'd5,  32'hFFFF_FFFF, MUL_LAT};
    vecs[5]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 5'd6,  32'h0000_0000, MUL_LAT};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, DIV_LAT};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, DIV_LAT};
    vecs[8]  = '{3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        DIV_LAT};
    vecs[9]  = '{3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         DIV_LAT};
    vecs[10] = '{3'b101, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    vecs[11] = '{3'b111, 32'd5,         32'd0,         5'd12, 32'd5,         1};
    vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1};
    vecs[14] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, DIV_LAT};
    vecs[15] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'd1,         DIV_LAT};
    vecs[16] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd17, 32'd3,         DIV_LAT};
    vecs[17] = '{3'b110, 32'hFFFF_FFF7, 32'd0,         5'd18, 32'hFFFF_FFF7, 1};
    vecs[18] = '{3'b100, 32'd9,         32'd0,         5'd19, 32'hFFFF_FFFF, 1};
    vecs[19] = '{3'b101, 32'hFFFF_FFFF, 32'd1,         5'd20, 32'hFFFF_FFFF, DIV_LAT};

    rst_n       = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    operator_i  = 3'b000;
    operand_a_i = '0;
    operand_b_i = '0;
    rd_i        = '0;
    repeat (3) @(negedge clk);
    checkFlag("reset rsp_valid", rsp_valid_o, 1'b0);
    checkFlag("reset busy", busy_o, 1'b0);
    checkFlag("reset req_ready", req_ready_o, 1'b1);
    checkOutput("reset result", result_o, '0);
    checkOutput("reset rd", {27'd0, rd_o}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Consumer stall: response must hold and no new request may slip in.
    issueOnly(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9);
    for (int i = 0; i < MUL_LAT + 2 && !rsp_valid_o; i++) begin
      @(posedge clk);
      #1;
    end
    checkFlag("stall rsp_valid", rsp_valid_o, 1'b1);
    @(negedge clk);
    operator_i  = 3'b101;
    operand_a_i = 32'd50;
    operand_b_i = 32'd5;
    rd_i        = 5'd30;
    req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d result", i), result_o, 32'hFFFF_FFEB);
      checkOutput($sformatf("stall%0d rd", i), {27'd0, rd_o}, {27'd0, 5'd9});
      checkFlag($sformatf("stall%0d req_ready", i), req_ready_o, 1'b0);
    end
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    checkFlag("no accept in response handshake", busy_o, 1'b0);
    checkFlag("rsp dropped after handshake", rsp_valid_o, 1'b0);

    // Flush on the tenth divide iteration.
    issueOnly(3'b101, 32'd100, 32'd7, 5'd22);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkFlag("flush busy", busy_o, 1'b0);
    checkFlag("flush req_ready", req_ready_o, 1'b1);
    watchNoResponse("flush no response", 40);

    // Flush beats a request arriving in the same cycle.
    @(negedge clk);
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    operator_i  = 3'b000;
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    checkFlag("flush blocks accept", busy_o, 1'b0);

    // Flush drops a waiting response.
    issueOnly(3'b011, 32'd3, 32'd4, 5'd23);
    repeat (MUL_LAT) @(posedge clk);
    #1;
    checkFlag("pre-flush rsp_valid", rsp_valid_o, 1'b1);
    @(negedge clk);
    flush_i     = 1'b1;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b0;
    checkFlag("flush in done drops rsp", rsp_valid_o, 1'b0);

    // Asynchronous reset in the middle of a signed divide.
    issueOnly(3'b100, 32'hFFFF_FF00, 32'd3, 5'd24);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkFlag("mid-div reset busy", busy_o, 1'b0);
    checkFlag("mid-div reset rsp_valid", rsp_valid_o, 1'b0);
    checkOutput("mid-div reset result", result_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    watchNoResponse("reset no response", 40);

    applyStimulus('{3'b000, 32'd6, 32'd7, 5'd21, 32'd42, MUL_LAT}, "post-reset mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
